// File: rtl/mspu_pkg.sv
// Shared memory-stage definitions.
// Access-width codes and the memory FSM states.
package mspu_pkg;

  localparam logic [1:0] BYTES_WORD = 2'd0;
  localparam logic [1:0] BYTES_BYTE = 2'd1;
  localparam logic [1:0] BYTES_HALF = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } mem_state_t;

endpackage

// File: rtl/load_extract.sv
// Load lane selection and extension.
// Picks the addressed byte/half from a full read word.
module load_extract
  import mspu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  bytes_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  always_comb begin
    byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
    sgn    = 1'b0;
    data_o = rdata_i;
    unique case (1'b1)
      (bytes_i == BYTES_BYTE): begin
        sgn    = ~unsigned_i & byte_v[7];
        data_o = {{24{sgn}}, byte_v};
      end
      (bytes_i == BYTES_HALF): begin
        sgn    = ~unsigned_i & half_v[15];
        data_o = {{16{sgn}}, half_v};
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: data-memory loads/stores
// over a valid/ready channel, ALU results pass through.
module memory_access
  import mspu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] alu_result,
  input  logic        mem_to_reg_in,
  input  logic [1:0]  bytes_in,
  input  logic [31:0] wdata_in,
  input  logic        we_in,
  input  logic        re_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  input  logic        unsigned_flag,
  output logic        stall,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        run_out,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        misalign
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [1:0]  bytes_q, bytes_d;
  logic        uns_q, uns_d;
  logic        m2r_q, m2r_d;
  logic [4:0]  rd_q, rd_d;
  logic        rwe_q, rwe_d;
  logic        run_out_q, run_out_d;
  logic        mis_q, mis_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        rwe_out_q, rwe_out_d;

  logic        is_mem;
  logic        is_mis;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  load_extract u_ext (
    .rdata_i    (dmem_rdata),
    .addr_i     (addr_q[1:0]),
    .bytes_i    (bytes_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  // Store lane placement and alignment check on the incoming op
  always_comb begin
    is_mem  = we_in | re_in;
    st_strb = 4'b1111;
    st_data = wdata_in;
    is_mis  = 1'b0;
    unique case (1'b1)
      (bytes_in == BYTES_BYTE): begin
        st_strb = 4'b0001 << alu_result[1:0];
        st_data = {4{wdata_in[7:0]}};
      end
      (bytes_in == BYTES_HALF): begin
        st_strb = 4'b0011 << alu_result[1:0];
        st_data = {2{wdata_in[15:0]}};
        is_mis  = alu_result[0];
      end
      default: is_mis = (alu_result[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    bytes_d   = bytes_q;
    uns_d     = uns_q;
    m2r_d     = m2r_q;
    rd_d      = rd_q;
    rwe_d     = rwe_q;
    run_out_d = 1'b0;
    mis_d     = 1'b0;
    wb_d      = wb_q;
    rd_out_d  = rd_out_q;
    rwe_out_d = rwe_out_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          if (!is_mem) begin
            run_out_d = 1'b1;
            wb_d      = alu_result;
            rd_out_d  = rd_in;
            rwe_out_d = reg_we_in;
          end else if (is_mis) begin
            run_out_d = 1'b1;
            mis_d     = 1'b1;
            wb_d      = alu_result;
            rd_out_d  = rd_in;
            rwe_out_d = 1'b0;
          end else begin
            state_d = REQ;
            addr_d  = alu_result;
            wdata_d = st_data;
            wstrb_d = we_in ? st_strb : 4'b0000;
            we_d    = we_in;
            bytes_d = bytes_in;
            uns_d   = unsigned_flag;
            m2r_d   = mem_to_reg_in;
            rd_d    = rd_in;
            rwe_d   = reg_we_in;
          end
        end
      end
      REQ: begin
        if (dmem_ready) begin
          if (we_q) begin
            state_d   = IDLE;
            run_out_d = 1'b1;
            wb_d      = addr_q;
            rd_out_d  = rd_q;
            rwe_out_d = rwe_q;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          state_d   = IDLE;
          run_out_d = 1'b1;
          wb_d      = m2r_q ? ld_data : addr_q;
          rd_out_d  = rd_q;
          rwe_out_d = rwe_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      bytes_q   <= '0;
      uns_q     <= 1'b0;
      m2r_q     <= 1'b0;
      rd_q      <= '0;
      rwe_q     <= 1'b0;
      run_out_q <= 1'b0;
      mis_q     <= 1'b0;
      wb_q      <= '0;
      rd_out_q  <= '0;
      rwe_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      bytes_q   <= bytes_d;
      uns_q     <= uns_d;
      m2r_q     <= m2r_d;
      rd_q      <= rd_d;
      rwe_q     <= rwe_d;
      run_out_q <= run_out_d;
      mis_q     <= mis_d;
      wb_q      <= wb_d;
      rd_out_q  <= rd_out_d;
      rwe_out_q <= rwe_out_d;
    end
  end

  assign stall      = (state_q != IDLE);
  assign dmem_valid = (state_q == REQ);
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_we    = we_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign run_out    = run_out_q;
  assign misalign   = mis_q;
  assign wb_data    = wb_q;
  assign rd_out     = rd_out_q;
  assign reg_we_out = rwe_out_q;

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the core pipeline, sitting directly downstream of the execute stage. It consumes the execute stage's registered outputs (ALU result as address, store data, width, load/store enables, destination register) and performs data-memory loads and stores through a valid/ready request channel plus a response-valid channel. Non-memory instructions pass through in one cycle. The block stalls the execute stage while a memory transaction is outstanding and delivers sign- or zero-extended load data to write-back.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  instruction-valid qualifier from execute stage, sampled every cycle
- alu_result  in  32  ALU result; used as byte address for memory ops, as write-back data otherwise
- mem_to_reg_in  in  1  write-back source select: 1 = load data, 0 = alu_result
- bytes_in  in  2  access width: 0 = word, 1 = byte, 2 = halfword, 3 = treated as word
- wdata_in  in  32  store data, right-aligned
- we_in  in  1  store enable
- re_in  in  1  load enable
- rd_in  in  5  destination register
- reg_we_in  in  1  register-write enable
- unsigned_flag  in  1  1 = zero-extend loads, 0 = sign-extend
- stall  out  1  holds execute stage; equals (state != IDLE)
- dmem_valid  out  1  request valid
- dmem_ready  in  1  request accepted when dmem_valid && dmem_ready
- dmem_addr  out  32  word-aligned address (alu_result with [1:0] forced to 0)
- dmem_we  out  1  1 = write request, 0 = read request
- dmem_wstrb  out  4  byte-lane strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_rvalid  in  1  read-data valid, one cycle
- dmem_rdata  in  32  read data, full word
- run_out  out  1  one-cycle pulse: instruction completed, outputs valid
- wb_data  out  32  write-back value
- rd_out  out  5  destination register
- reg_we_out  out  1  register-write enable (forced 0 on misalign)
- misalign  out  1  one-cycle pulse with run_out on misaligned access

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, run=1, we_in=re_in=0: register wb_data=alu_result, rd_out, reg_we_out, run_out=1; stay IDLE.
- IDLE, run=1, we_in or re_in, misaligned (half with addr[0]=1; word with addr[1:0]!=0): no memory request; run_out=1, misalign=1, reg_we_out=0; stay IDLE.
- IDLE, run=1, aligned memory op: latch all inputs, go REQ.
- REQ: dmem_valid=1, fields stable until handshake. On dmem_ready: store → IDLE with run_out=1, reg_we_out from latched value; load → WAIT_R.
- WAIT_R: on dmem_rvalid, extract lane by addr[1:0] and width, extend per unsigned_flag, register wb_data, run_out=1 → IDLE. dmem_rvalid in any other state is ignored.
- Store lanes: byte → wstrb=4'b0001<<addr[1:0], wdata={4{wdata_in[7:0]}}; half → wstrb=4'b0011<<addr[1:0], wdata={2{wdata_in[15:0]}}; word → 4'b1111.
- we_in and re_in both set: treated as store.
- run_out, misalign are pulses; wb_data, rd_out, reg_we_out hold until next completion.

## Timing
- Reset: state IDLE; stall, dmem_valid, dmem_we, run_out, misalign, reg_we_out = 0; dmem_addr, dmem_wstrb, dmem_wdata, wb_data, rd_out = 0.
- Non-memory op: accepted cycle T, run_out at T+1, no stall.
- Store: accepted T, dmem_valid from T+1; ready at cycle R → run_out at R+1. Minimum latency 2.
- Load: accepted T, handshake R ≥ T+1, rvalid at V ≥ R+1 → run_out at V+1. Minimum latency 3.
- stall high from T+1 through the cycle completion is registered; low in the run_out cycle, when the next instruction may be accepted.
- dmem_ready and dmem_rvalid in the same cycle while in REQ: rvalid ignored; memory must respond at least one cycle after the handshake.
- Reset mid-transaction: abandon, dmem_valid low after the reset edge, no run_out, late responses ignored.

## Structure
- Shared package mspu_pkg: width constants (BYTES_WORD=0, BYTES_BYTE=1, BYTES_HALF=2) and state enum mem_state_t.
- One combinational sub-module load_extract (rdata, addr[1:0], bytes, unsigned_flag → 32-bit extended value).

## Test plan
- ALU op: run=1, alu_result=0x1234, rd_in=5, reg_we_in=1 → next cycle run_out=1, wb_data=0x1234, rd_out=5, stall=0.
- Store byte: addr=0x103, wdata_in=0xAB, ready after 2 wait cycles → dmem_wstrb=4'b1000, dmem_wdata=0xABABABAB, stall until completion.
- Signed load byte: addr=0x102, rdata=0x0080_0000, unsigned_flag=0 → wb_data=0xFFFFFF80; with unsigned_flag=1 → 0x00000080.
- Halfword load: addr=0x202, rdata=0x8001_0000, signed → wb_data=0xFFFF8001.
- Misaligned word load: addr=0x101 → no dmem_valid, run_out=1, misalign=1, reg_we_out=0.
- Reset while in WAIT_R: then rvalid pulse → no run_out, state IDLE, stall=0.
